// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// The helpers work on fixed maximum widths so that one definition serves any
// parameterisation. Callers zero-extend their buses to MAX_BUS_W and truncate
// the results back down.
// Supported limits: NWR <= MAX_PORTS, NWR*XLEN and NRD*AW <= MAX_BUS_W, and
// XLEN <= MAX_SLICE_W.
package regfile_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned REG_ZERO    = 0;

    localparam int unsigned MAX_BUS_W   = 2048;
    localparam int unsigned MAX_SLICE_W = 128;
    localparam int unsigned MAX_PORTS   = 16;
    localparam int unsigned PORT_IDX_W  = 4;

    // Result of a write-port search: whether any port matched, and the
    // highest matching port index.
    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] idx;
    } port_sel_t;

    // Return field 'idx' of width 'w' from a flattened bus, zero-extended.
    function automatic logic [MAX_SLICE_W-1:0] slice_bus(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_SLICE_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = (w >= MAX_SLICE_W) ? '1
                                     : ((MAX_SLICE_W'(1) << w) - MAX_SLICE_W'(1));
        return shifted[MAX_SLICE_W-1:0] & mask;
    endfunction

    // Find the highest-index enabled write port whose address equals 'addr'.
    // Later ports overwrite earlier matches, so the highest index wins.
    function automatic port_sel_t prio_select(
        input logic [MAX_PORTS-1:0]   en,
        input logic [MAX_BUS_W-1:0]   addr_bus,
        input int unsigned            aw,
        input int unsigned            nports,
        input logic [MAX_SLICE_W-1:0] addr
    );
        port_sel_t sel;
        sel = '0;
        for (int unsigned j = 0; j < MAX_PORTS; j++) begin
            if ((j < nports) && en[j] && (slice_bus(addr_bus, j, aw) == addr)) begin
                sel.hit = 1'b1;
                sel.idx = PORT_IDX_W'(j);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking. Writeback releases a register, issue claims it.
// A claim beats a same-cycle release, flush beats everything but reset,
// and register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_byp_hit,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy state: release on write, then claim on alloc, then flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy register; synchronous reset forgets every pending producer.
    always_ff @(posedge clk) begin
        busy_q <= rst ? '0 : busy_d;
    end

    assign busy_vec = {busy_q[NREG-1:1], 1'b0};

    // Source busy per read port, hidden for x0 and for operands arriving via bypass.
    for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
        logic [AW-1:0] addr;
        assign addr       = rd_addr[i*AW +: AW];
        assign rd_busy[i] = busy_q[addr] && (addr != AW'(REG_ZERO)) && !rd_byp_hit[i];
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with an integrated busy scoreboard.
// Storage and read/bypass muxing live here. Busy tracking is in
// regfile_scoreboard. Reads are combinational. Writes land at the clock edge.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NRD-1:0]  rd_byp_hit;

    // Next register contents: per register, the highest-index matching writer wins; x0 stays zero.
    always_comb begin : c_regs_next
        port_sel_t sel;
        sel = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            if (r != REG_ZERO) begin
                sel = prio_select(MAX_PORTS'(wr_en), MAX_BUS_W'(wr_addr), AW, NWR,
                                  MAX_SLICE_W'(r));
                if (sel.hit) begin
                    regs_d[r] = XLEN'(slice_bus(MAX_BUS_W'(wr_data), 32'(sel.idx), XLEN));
                end
            end
        end
    end

    // Storage update; reset clears every register and suppresses same-cycle writes.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            regs_q[r] <= rst ? '0 : regs_d[r];
        end
    end

    // Read ports: x0 reads zero; with bypass, a same-cycle write to the address is forwarded.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        port_sel_t     sel;
        logic [XLEN-1:0] byp_data;

        assign addr     = AW'(slice_bus(MAX_BUS_W'(rd_addr), i, AW));
        assign sel      = prio_select(MAX_PORTS'(wr_en), MAX_BUS_W'(wr_addr), AW, NWR,
                                      MAX_SLICE_W'(addr));
        assign byp_data = XLEN'(slice_bus(MAX_BUS_W'(wr_data), 32'(sel.idx), XLEN));

        assign rd_byp_hit[i] = (BYPASS != 0) && sel.hit && (addr != AW'(REG_ZERO));

        assign rd_data[i*XLEN +: XLEN] = (addr == AW'(REG_ZERO)) ? '0
                                       : rd_byp_hit[i]          ? byp_data
                                       :                          regs_q[addr];
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_byp_hit (rd_byp_hit),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing instance share
// stimulus. A behavioural model (array of values plus busy flags) predicts
// reads, busy flags and busy_vec.
module tb_regfile_mp_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [NREG-1:0]     busy_vec, busy_vec_nb;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec_nb)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs,
                            input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference read: zero for x0; else stored value, replaced by the last
    // (highest-index) same-cycle writer when bypassing.
    function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 1; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic check_all(input string ctx);
        int a;
        if (!rst) begin
            for (int i = 0; i < NRD; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                check_eq($sformatf("%s rd_data%0d a=%0d", ctx, i, a),
                         rd_data[i*XLEN +: XLEN], exp_rd(a, 1'b1));
                check_eq($sformatf("%s rd_busy%0d a=%0d", ctx, i, a),
                         XLEN'(rd_busy[i]), XLEN'(exp_busy(a, 1'b1)));
                check_eq($sformatf("%s nb rd_data%0d a=%0d", ctx, i, a),
                         rd_data_nb[i*XLEN +: XLEN], exp_rd(a, 1'b0));
                check_eq($sformatf("%s nb rd_busy%0d a=%0d", ctx, i, a),
                         XLEN'(rd_busy_nb[i]), XLEN'(exp_busy(a, 1'b0)));
            end
        end
        check_eq({ctx, " busy_vec"}, XLEN'(busy_vec), XLEN'(exp_vec()));
        check_eq({ctx, " nb busy_vec"}, XLEN'(busy_vec_nb), XLEN'(exp_vec()));
    endtask

    task automatic model_edge();
        int a;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    a = int'(wr_addr[j*AW +: AW]);
                    if (a != 0) m_regs[a] = wr_data[j*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
            if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end
    endtask

    task automatic settle(input string ctx);
        #1;
        check_all(ctx);
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        idle();
        set_rd(0, 0);
        #1;

        // Reset then read
        rst = 1'b1;
        clock();
        idle(); set_rd(5, 0);
        settle("reset");
        check_eq("reset rd5", rd_data[0 +: XLEN], '0);
        check_eq("reset rd0", rd_data[XLEN +: XLEN], '0);
        check_eq("reset busy_vec", XLEN'(busy_vec), '0);
        clock();

        // Write / read back, and x0
        set_wr(0, 3, 64'hDEAD); set_rd(1, 2);
        settle("wr3");
        clock();
        idle(); set_rd(3, 0);
        settle("rd3");
        check_eq("readback a3", rd_data[0 +: XLEN], 64'hDEAD);
        clock();
        set_wr(0, 0, 64'h1234); set_rd(0, 0);
        settle("wr0");
        check_eq("x0 same-cycle", rd_data[0 +: XLEN], '0);
        clock();
        idle(); set_rd(0, 3);
        settle("rd0");
        check_eq("x0 after write", rd_data[0 +: XLEN], '0);
        check_eq("a3 kept", rd_data[XLEN +: XLEN], 64'hDEAD);
        clock();

        // Port conflict plus bypass
        set_wr(0, 7, 64'h11); set_wr(1, 7, 64'h22); set_rd(7, 7);
        settle("conflict");
        check_eq("bypass highest port", rd_data[0 +: XLEN], 64'h22);
        check_eq("no-bypass old value", rd_data_nb[0 +: XLEN], 64'h0);
        clock();
        idle(); set_rd(7, 0);
        settle("conflict after");
        check_eq("stored highest port", rd_data[0 +: XLEN], 64'h22);
        check_eq("nb stored highest port", rd_data_nb[0 +: XLEN], 64'h22);
        clock();

        // Scoreboard set/clear
        alloc_en = 1'b1; alloc_addr = AW'(9); set_rd(9, 0);
        settle("alloc9");
        check_eq("alloc same-cycle invisible", XLEN'(rd_busy[0]), '0);
        clock();
        idle(); set_rd(9, 9);
        settle("busy9");
        check_eq("busy_vec[9] set", XLEN'(busy_vec[9]), 64'd1);
        check_eq("rd_busy a9", XLEN'(rd_busy[0]), 64'd1);
        clock();
        set_wr(0, 9, 64'h99); set_rd(9, 0);
        settle("wr9");
        check_eq("rd_busy masked by bypass", XLEN'(rd_busy[0]), '0);
        check_eq("nb rd_busy not masked", XLEN'(rd_busy_nb[0]), 64'd1);
        check_eq("bypass data a9", rd_data[0 +: XLEN], 64'h99);
        clock();
        idle();
        settle("after wr9");
        check_eq("busy_vec[9] cleared", XLEN'(busy_vec[9]), '0);
        clock();

        // Simultaneous events
        alloc_en = 1'b1; alloc_addr = AW'(4); set_wr(1, 4, 64'h44); set_rd(4, 0);
        settle("alloc+wr4");
        clock();
        idle();
        settle("after alloc+wr4");
        check_eq("alloc beats write", XLEN'(busy_vec[4]), 64'd1);
        alloc_en = 1'b1; alloc_addr = AW'(6); flush = 1'b1;
        settle("flush+alloc6");
        clock();
        idle();
        settle("after flush");
        check_eq("flush beats alloc", XLEN'(busy_vec), '0);
        alloc_en = 1'b1; alloc_addr = '0;
        settle("alloc0");
        clock();
        idle();
        settle("after alloc0");
        check_eq("alloc x0 ignored", XLEN'(busy_vec), '0);

        // Reset mid-operation
        for (int r = 1; r < NREG; r += 2) begin
            idle();
            set_wr(0, r, {$urandom, $urandom});
            if (r + 1 < NREG) set_wr(1, r + 1, {$urandom, $urandom});
            set_rd(r, r + 1 < NREG ? r + 1 : 0);
            settle("fill");
            clock();
        end
        idle(); alloc_en = 1'b1; alloc_addr = AW'(2);
        clock();
        alloc_addr = AW'(5);
        clock();
        idle();
        settle("busy 2,5");
        check_eq("busy 2,5 set", XLEN'(busy_vec), XLEN'(32'h24));
        rst = 1'b1; set_wr(0, 8, 64'hFF); alloc_en = 1'b1; alloc_addr = AW'(3);
        settle("mid reset");
        clock();
        idle();
        for (int r = 0; r < NREG; r += 2) begin
            set_rd(r, r + 1);
            settle("post reset");
            check_eq($sformatf("post reset rd%0d", r), rd_data[0 +: XLEN], '0);
            check_eq($sformatf("post reset rd%0d", r + 1), rd_data[XLEN +: XLEN], '0);
        end
        check_eq("post reset busy_vec", XLEN'(busy_vec), '0);
        set_rd(8, 0);
        settle("reg8");
        check_eq("reg8 write blocked by reset", rd_data[0 +: XLEN], '0);
        clock();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NWR; p++) begin
                if ($urandom_range(0, 2) != 0) set_wr(p, rnd_addr(), {$urandom, $urandom});
            end
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'(rnd_addr());
            flush      = ($urandom_range(0, 29) == 0);
            set_rd(rnd_addr(), rnd_addr());
            settle("random");
            clock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with an integrated scoreboard. It is the next generation of the single-write, dual-read core register file.
- Adds configurable read and write port counts, same-cycle write-to-read bypass, and per-register busy tracking for a pipelined or out-of-order-issue core.
- Sits between decode/issue, which reads and allocates, and writeback, which writes and releases.

Parameters:
- XLEN, 64, data width per register.
- NREG, 32, number of architectural registers. Power of two, >= 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = read ports see same-cycle writes; 0 = read returns registered value only.
- AW (localparam), $clog2(NREG), register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; combinational from rd_addr
- rd_busy  out  NRD  source register still has a pending producer
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr busy (instruction issued with destination)
- alloc_addr  in  AW  destination being allocated
- flush  in  1  clear all busy bits (pipeline squash); register data untouched
- busy_vec  out  NREG  registered busy bits; bit 0 is always 0

Behaviour:
- Reset: all NREG registers and all busy bits go to 0 on the clk edge with rst=1. rst overrides wr_en, alloc_en and flush in that cycle; no write lands.
- Register 0 is hardwired to zero:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 with rd_busy=0;
  - alloc of address 0 is ignored.
- Write timing: data is stored at the clk edge. The value is visible via registered read from the next cycle.
- Write conflict: if several ports write the same address in one cycle, the highest port index wins. Lower-index data is discarded.
- Read, BYPASS=1: if any wr_en[j] has wr_addr[j]==rd_addr[i]!=0 this cycle, rd_data[i] = wr_data of the highest such j. Otherwise rd_data[i] is the stored value.
- Read, BYPASS=0: rd_data[i] is always the stored value.
- Read latency is zero (combinational). Reads never stall.
- Busy set: alloc_en=1 sets busy[alloc_addr] at the next edge.
- Busy clear: any wr_en[j] with address a clears busy[a] at the next edge.
- Alloc and write to the same address in the same cycle: alloc wins and the bit ends set. This models a new producer replacing the old one.
- flush=1: all busy bits become 0 at the next edge. flush wins over a simultaneous alloc_en, so no bit is set. Same-cycle writes still update data.
- rd_busy[i] = busy_q[rd_addr[i]], masked to 0 when:
  - rd_addr[i]==0, or
  - BYPASS=1 and a same-cycle write targets rd_addr[i] (the operand arrives via the bypass).
- Same-cycle alloc does not affect rd_busy. Allocation becomes visible from the next cycle.
- busy_vec = busy_q directly, with bit 0 forced to 0.
- Reset mid-operation: all pending producers are forgotten (busy=0) and data is cleared. Later writes behave normally.

Decomposition:
- Package regfile_pkg:
  - default XLEN/NREG constants;
  - REG_ZERO index constant;
  - a function to slice a flattened port bus by index;
  - a priority-select function (highest matching write port).
- Sub-module regfile_scoreboard (busy bits, set/clear/flush/reset priority, rd_busy masking inputs). The storage array and bypass muxing stay in the top.

Test Plan:
1. Reset then read: rst 1 cycle, rd_addr={5,0} -> rd_data={0,0}, busy_vec=0.
2. Write/read-back and x0:
   - wr port0 a=3 d=0xDEAD, next cycle rd a=3 -> 0xDEAD.
   - wr a=0 d=0x1234 -> rd a=0 returns 0.
3. Port conflict plus bypass:
   - wr0 a=7 d=0x11 and wr1 a=7 d=0x22 same cycle, rd a=7 same cycle -> 0x22 (BYPASS=1). Next cycle stored value is 0x22.
   - BYPASS=0 build: same-cycle read returns the old value.
4. Scoreboard:
   - alloc a=9 -> busy_vec[9]=1 next cycle, rd_busy=1.
   - Write a=9 -> rd_busy=0 in the write cycle (bypass) and busy_vec[9]=0 after.
5. Simultaneous events:
   - alloc a=4 + wr a=4 same cycle -> busy_vec[4]=1.
   - flush + alloc a=6 -> busy_vec=0.
6. Reset mid-operation: regs 1..31 written and busy bits 2,5 set, then rst asserted with wr_en a=8 d=0xFF -> all reads 0, busy_vec=0, reg 8=0.
